// File: rtl/de_pipe_reg.sv
// D->E pipeline register: latches decoded D fields into E, drives the E-stage
// multiply/divide unit, and generates the structural stall for back-to-back mult/div use.
module de_pipe_reg #(
    parameter logic [31:0] EXC_PC  = 32'h0000_4180,
    parameter logic [3:0]  MD_NONE = 4'b1111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        data_stall,
    input  logic        MD_busy,
    input  logic [31:0] D_PC,
    input  logic [31:0] D_Instr,
    input  logic [31:0] D_RD1,
    input  logic [31:0] D_RD2,
    input  logic [31:0] D_EXT,
    input  logic [3:0]  D_MDCtrl,
    input  logic        D_MDStart,
    input  logic        D_BD,
    input  logic [4:0]  D_ExcCode,
    output logic        stall,
    output logic [31:0] E_PC,
    output logic [31:0] E_Instr,
    output logic [31:0] E_RD1,
    output logic [31:0] E_RD2,
    output logic [31:0] E_EXT,
    output logic [3:0]  E_MDCtrl,
    output logic        E_start,
    output logic        E_BD,
    output logic [4:0]  E_ExcCode,
    output logic [31:0] md_stall_cnt
);

    logic        d_is_md;
    logic        md_stall;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] rd1_q, rd1_d;
    logic [31:0] rd2_q, rd2_d;
    logic [31:0] ext_q, ext_d;
    logic [3:0]  md_ctrl_q, md_ctrl_d;
    logic        start_q, start_d;
    logic        bd_q, bd_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] md_stall_cnt_q, md_stall_cnt_d;

    // A mult/div-class instruction in D waits while the unit is busy or has just been started,
    // which also keeps E_start from ever pulsing on consecutive cycles.
    assign d_is_md  = (D_MDCtrl != MD_NONE);
    assign md_stall = d_is_md & (MD_busy | start_q);
    assign stall    = md_stall | data_stall;

    always_comb begin
        pc_d           = D_PC;
        instr_d        = D_Instr;
        rd1_d          = D_RD1;
        rd2_d          = D_RD2;
        ext_d          = D_EXT;
        md_ctrl_d      = D_MDCtrl;
        start_d        = D_MDStart;
        bd_d           = D_BD;
        exc_code_d     = D_ExcCode;
        md_stall_cnt_d = md_stall_cnt_q;

        if (Req) begin
            pc_d       = EXC_PC;
            instr_d    = '0;
            rd1_d      = '0;
            rd2_d      = '0;
            ext_d      = '0;
            md_ctrl_d  = MD_NONE;
            start_d    = 1'b0;
            bd_d       = 1'b0;
            exc_code_d = '0;
        end else if (stall) begin
            // Bubble keeps PC and delay-slot flag so an interrupt taken here gets a valid EPC.
            instr_d    = '0;
            rd1_d      = '0;
            rd2_d      = '0;
            ext_d      = '0;
            md_ctrl_d  = MD_NONE;
            start_d    = 1'b0;
            exc_code_d = '0;
        end else if (D_ExcCode != 5'd0) begin
            md_ctrl_d  = MD_NONE;
            start_d    = 1'b0;
        end

        if (md_stall && !Req && (md_stall_cnt_q != 32'hFFFF_FFFF)) begin
            md_stall_cnt_d = md_stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q           <= '0;
            instr_q        <= '0;
            rd1_q          <= '0;
            rd2_q          <= '0;
            ext_q          <= '0;
            md_ctrl_q      <= MD_NONE;
            start_q        <= 1'b0;
            bd_q           <= 1'b0;
            exc_code_q     <= '0;
            md_stall_cnt_q <= '0;
        end else begin
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            rd1_q          <= rd1_d;
            rd2_q          <= rd2_d;
            ext_q          <= ext_d;
            md_ctrl_q      <= md_ctrl_d;
            start_q        <= start_d;
            bd_q           <= bd_d;
            exc_code_q     <= exc_code_d;
            md_stall_cnt_q <= md_stall_cnt_d;
        end
    end

    assign E_PC         = pc_q;
    assign E_Instr      = instr_q;
    assign E_RD1        = rd1_q;
    assign E_RD2        = rd2_q;
    assign E_EXT        = ext_q;
    assign E_MDCtrl     = md_ctrl_q;
    assign E_start      = start_q;
    assign E_BD         = bd_q;
    assign E_ExcCode    = exc_code_q;
    assign md_stall_cnt = md_stall_cnt_q;

endmodule

// File: tb/tb_de_pipe_reg.sv
// Bench for de_pipe_reg: vector table with an expected-output queue, plus hand-written
// sequences for mid-cycle reset, back-to-back mult/mflo and counter saturation.
module tb_de_pipe_reg;
  localparam int PW = 171;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req, data_stall, MD_busy;
  logic [31:0] D_PC, D_Instr, D_RD1, D_RD2, D_EXT;
  logic [3:0]  D_MDCtrl;
  logic        D_MDStart, D_BD;
  logic [4:0]  D_ExcCode;
  logic        stall;
  logic [31:0] E_PC, E_Instr, E_RD1, E_RD2, E_EXT;
  logic [3:0]  E_MDCtrl;
  logic        E_start, E_BD;
  logic [4:0]  E_ExcCode;
  logic [31:0] md_stall_cnt;

  int total = 0;
  int bad   = 0;

  logic [PW-1:0] exp_q[$];

  typedef struct {
    logic        req, ds, busy;
    logic [31:0] pc, instr;
    logic [3:0]  md;
    logic        st, bd;
    logic [4:0]  exc;
    logic        x_stall;
    logic [31:0] x_pc, x_instr;
    logic [3:0]  x_md;
    logic        x_st, x_bd;
    logic [4:0]  x_exc;
    logic        x_pass;
  } vec_t;

  vec_t vt[13];

  de_pipe_reg dut (
    .clk(clk), .reset(reset), .Req(Req), .data_stall(data_stall), .MD_busy(MD_busy),
    .D_PC(D_PC), .D_Instr(D_Instr), .D_RD1(D_RD1), .D_RD2(D_RD2), .D_EXT(D_EXT),
    .D_MDCtrl(D_MDCtrl), .D_MDStart(D_MDStart), .D_BD(D_BD), .D_ExcCode(D_ExcCode),
    .stall(stall), .E_PC(E_PC), .E_Instr(E_Instr), .E_RD1(E_RD1), .E_RD2(E_RD2),
    .E_EXT(E_EXT), .E_MDCtrl(E_MDCtrl), .E_start(E_start), .E_BD(E_BD),
    .E_ExcCode(E_ExcCode), .md_stall_cnt(md_stall_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] dut_pk();
    return {E_PC, E_Instr, E_RD1, E_RD2, E_EXT, E_MDCtrl, E_start, E_BD, E_ExcCode};
  endfunction

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive_d(input logic [31:0] pc, input logic [31:0] instr, input logic [3:0] md,
                         input logic st, input logic bd, input logic [4:0] exc);
    D_PC = pc; D_Instr = instr; D_MDCtrl = md; D_MDStart = st; D_BD = bd; D_ExcCode = exc;
    D_RD1 = $urandom; D_RD2 = $urandom; D_EXT = $urandom;
  endtask

  task automatic drive_idle();
    Req = 1'b0; data_stall = 1'b0; MD_busy = 1'b0;
    drive_d(32'h0, 32'h0, 4'hF, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    logic [PW-1:0] e;
    logic [PW-1:0] rst_pk;
    int nstall;

    rst_pk = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'hF, 1'b0, 1'b0, 5'd0};

    vt[0]  = '{1'b0,1'b0,1'b0, 32'h3000,32'h00221821,4'hF,1'b0,1'b0,5'd0,  1'b0, 32'h3000,32'h00221821,4'hF,1'b0,1'b0,5'd0, 1'b1};
    vt[1]  = '{1'b0,1'b0,1'b0, 32'h3004,32'h00850018,4'h0,1'b1,1'b0,5'd0,  1'b0, 32'h3004,32'h00850018,4'h0,1'b1,1'b0,5'd0, 1'b1};
    vt[2]  = '{1'b0,1'b0,1'b0, 32'h3008,32'h00001812,4'h5,1'b0,1'b1,5'd0,  1'b1, 32'h3008,32'h0,4'hF,1'b0,1'b1,5'd0, 1'b0};
    vt[3]  = '{1'b0,1'b0,1'b1, 32'h3008,32'h00001812,4'h5,1'b0,1'b1,5'd0,  1'b1, 32'h3008,32'h0,4'hF,1'b0,1'b1,5'd0, 1'b0};
    vt[4]  = '{1'b0,1'b0,1'b0, 32'h3008,32'h00001812,4'h5,1'b0,1'b1,5'd0,  1'b0, 32'h3008,32'h00001812,4'h5,1'b0,1'b1,5'd0, 1'b1};
    vt[5]  = '{1'b0,1'b1,1'b0, 32'h300C,32'h8C430000,4'hF,1'b0,1'b1,5'd0,  1'b1, 32'h300C,32'h0,4'hF,1'b0,1'b1,5'd0, 1'b0};
    vt[6]  = '{1'b1,1'b1,1'b1, 32'h3010,32'h00850018,4'h0,1'b1,1'b1,5'd3,  1'b1, 32'h4180,32'h0,4'hF,1'b0,1'b0,5'd0, 1'b0};
    vt[7]  = '{1'b0,1'b0,1'b0, 32'h3014,32'h0085001A,4'h2,1'b1,1'b0,5'd10, 1'b0, 32'h3014,32'h0085001A,4'hF,1'b0,1'b0,5'd10, 1'b1};
    vt[8]  = '{1'b0,1'b0,1'b0, 32'h3018,32'h0085001B,4'h3,1'b1,1'b0,5'd0,  1'b0, 32'h3018,32'h0085001B,4'h3,1'b1,1'b0,5'd0, 1'b1};
    vt[9]  = '{1'b0,1'b0,1'b0, 32'h301C,32'h00221821,4'hF,1'b0,1'b1,5'd0,  1'b0, 32'h301C,32'h00221821,4'hF,1'b0,1'b1,5'd0, 1'b1};
    vt[10] = '{1'b0,1'b0,1'b1, 32'h3020,32'h00400011,4'h6,1'b0,1'b0,5'd0,  1'b1, 32'h3020,32'h0,4'hF,1'b0,1'b0,5'd0, 1'b0};
    vt[11] = '{1'b0,1'b1,1'b0, 32'h3020,32'h00400011,4'h6,1'b0,1'b0,5'd0,  1'b1, 32'h3020,32'h0,4'hF,1'b0,1'b0,5'd0, 1'b0};
    vt[12] = '{1'b1,1'b0,1'b0, 32'h3024,32'h00221821,4'hF,1'b0,1'b0,5'd5,  1'b0, 32'h4180,32'h0,4'hF,1'b0,1'b0,5'd0, 1'b0};

    // reset state before any clock edge
    reset = 1'b1;
    drive_idle();
    #2;
    chk("reset_fields", dut_pk(), rst_pk);
    chk("reset_cnt", md_stall_cnt, 32'h0);
    chk("reset_stall", stall, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // vector table with expected-output queue
    for (int i = 0; i < 13; i++) begin
      Req = vt[i].req; data_stall = vt[i].ds; MD_busy = vt[i].busy;
      drive_d(vt[i].pc, vt[i].instr, vt[i].md, vt[i].st, vt[i].bd, vt[i].exc);
      #1;
      chk($sformatf("vec%0d_stall", i), stall, vt[i].x_stall);
      exp_q.push_back({vt[i].x_pc, vt[i].x_instr,
                       vt[i].x_pass ? D_RD1 : 32'h0, vt[i].x_pass ? D_RD2 : 32'h0,
                       vt[i].x_pass ? D_EXT : 32'h0,
                       vt[i].x_md, vt[i].x_st, vt[i].x_bd, vt[i].x_exc});
      step();
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_e", i), dut_pk(), e);
    end
    chk("table_cnt", md_stall_cnt, 32'd3);

    // mid-cycle asynchronous reset
    drive_idle();
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_fields", dut_pk(), rst_pk);
    chk("midreset_cnt", md_stall_cnt, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // mult then mflo with the unit busy for 5 cycles after issue
    drive_d(32'h3000, 32'h00850018, 4'h0, 1'b1, 1'b0, 5'd0);
    #1;
    chk("b2b_issue_stall", stall, 1'b0);
    step();
    chk("b2b_issue_e", {E_PC, E_MDCtrl, E_start}, {32'h3000, 4'h0, 1'b1});
    drive_d(32'h3004, 32'h00001812, 4'h5, 1'b0, 1'b0, 5'd0);
    nstall = 0;
    for (int k = 0; k < 20; k++) begin
      MD_busy = (k >= 1 && k <= 5);
      #1;
      if (!stall) break;
      nstall++;
      step();
      chk($sformatf("b2b_bubble%0d", k), {E_PC, E_Instr, E_MDCtrl, E_start},
          {32'h3004, 32'h0, 4'hF, 1'b0});
    end
    chk("b2b_nstall", nstall, 6);
    step();
    chk("b2b_mflo_e", {E_PC, E_Instr, E_MDCtrl, E_start}, {32'h3004, 32'h00001812, 4'h5, 1'b0});
    chk("b2b_cnt", md_stall_cnt, 32'd6);

    // counter saturation
    drive_d(32'h3008, 32'h00850018, 4'h0, 1'b1, 1'b0, 5'd0);
    MD_busy = 1'b1;
    #1;
    force dut.md_stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.md_stall_cnt_q;
    chk("sat_preload", md_stall_cnt, 32'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("sat_cnt%0d", k), md_stall_cnt, 32'hFFFF_FFFF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/de_pipe_reg.md
Name: de_pipe_reg

Overview:
- D→E pipeline register of the P7 five-stage MIPS core.
- Latches decoded D-stage fields into E and drives the E-stage multiply/divide unit's start, control and operand inputs.
- Generates the multiply/divide structural stall from that unit's busy output and merges it with the data-hazard stall.
- Handles interrupt/exception flush, bubble insertion and a saturating multiply/divide stall counter.

Parameters:
- EXC_PC, 32'h0000_4180, PC loaded into E on flush (exception handler entry).
- MD_NONE, 4'b1111, MDCtrl code meaning "no multiply/divide operation".

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Req  in  1  interrupt/exception request from M stage; flushes E.
- data_stall  in  1  data-hazard stall from the hazard unit.
- MD_busy  in  1  busy output of the E-stage multiply/divide unit.
- D_PC  in  32  D-stage PC.
- D_Instr  in  32  D-stage instruction word.
- D_RD1, D_RD2  in  32 each  forwarded GRF read data.
- D_EXT  in  32  extended immediate.
- D_MDCtrl  in  4  multiply/divide control code.
  - 0000 mult, 0001 multu, 0010 div, 0011 divu.
  - 0100 mfhi, 0101 mflo, 0110 mthi, 0111 mtlo.
  - 1111 none.
- D_MDStart  in  1  D instruction is mult/multu/div/divu.
- D_BD  in  1  D instruction is in a branch delay slot.
- D_ExcCode  in  5  exception code accumulated so far (0 = none).
- stall  out  1  freeze PC and F/D register.
- E_PC, E_Instr, E_RD1, E_RD2, E_EXT  out  32 each  registered fields.
- E_MDCtrl  out  4  control code to the multiply/divide unit.
- E_start  out  1  start pulse to the multiply/divide unit.
- E_BD  out  1  registered delay-slot flag.
- E_ExcCode  out  5  registered exception code.
- md_stall_cnt  out  32  saturating count of multiply/divide stall cycles.

Behaviour:
- Internal signals:
  - d_is_md = (D_MDCtrl != MD_NONE).
  - md_stall = d_is_md & (MD_busy | E_start).
  - stall = md_stall | data_stall, purely combinational.
- Reset (asynchronous, immediate on reset high):
  - E_PC, E_Instr, E_RD1, E_RD2 and E_EXT = 0.
  - E_MDCtrl = MD_NONE; E_start = 0.
  - E_BD = 0; E_ExcCode = 0.
  - md_stall_cnt = 0.
- Priority at each rising edge: Req > stall > normal load.
- Req = 1 (flush):
  - E_PC = EXC_PC.
  - All other fields cleared as at reset; E_MDCtrl = MD_NONE.
  - Ignores stall and D inputs.
- stall = 1, Req = 0 (bubble):
  - E_Instr = 0; E_RD1, E_RD2 and E_EXT = 0; E_ExcCode = 0.
  - E_MDCtrl = MD_NONE; E_start = 0.
  - E_PC = D_PC and E_BD = D_BD, so the bubble carries a valid EPC and delay-slot flag for the interrupt logic.
- Otherwise (normal load): every E_* field takes its D_* counterpart, and E_start = D_MDStart.
  - Exception: if D_ExcCode != 0, E_MDCtrl = MD_NONE and E_start = 0; a faulting instruction never touches HI/LO.
- E_start timing:
  - High for exactly one cycle per issued mult/div instruction.
  - Two back-to-back mult/div instructions never produce consecutive E_start pulses: the second stalls while E_start or MD_busy is high.
- md_stall_cnt:
  - Increments by 1 on each edge where md_stall = 1 and Req = 0.
  - Saturates at 32'hFFFF_FFFF.
  - Unaffected by data_stall-only cycles.
  - Cleared only by reset.
- Latency: one cycle D→E; stall is combinational (zero cycles).
- Reset asserted mid-stall clears all state immediately. After release, stall follows the inputs combinationally, so MD_busy = 0 yields stall = 0 even when a mult/div is waiting in D.

Test Plan:
- Reset: assert reset mid-cycle with E fields non-zero → all outputs 0, E_MDCtrl = 4'hF, immediately (before the next clk edge).
- Normal issue: D_PC = 32'h0000_3000, D_MDCtrl = 0000, D_MDStart = 1, MD_busy = 0, E_start = 0 → stall = 0; next edge E_PC = 0x3000, E_MDCtrl = 0000, E_start = 1; following cycle E_start = 0 if D has no mult/div.
- Back-to-back: mult at 0x3000 then mflo (D_MDCtrl = 0101) at 0x3004, MD_busy high 5 cycles after issue → stall = 1 for 6 cycles. E receives bubbles with E_PC = 0x3004, E_Instr = 0. mflo enters E on the edge after MD_busy falls. md_stall_cnt = 6.
- Flush priority: Req = 1 and stall = 1 simultaneously, D_PC = 0x3010 → next edge E_PC = 0x4180, E_Instr = 0, E_start = 0, md_stall_cnt unchanged.
- Exception suppression: D_MDStart = 1, D_MDCtrl = 0010, D_ExcCode = 5'd10 → E_start = 0, E_MDCtrl = 4'hF, E_ExcCode = 10.
- Counter saturation: force md_stall_cnt to 32'hFFFF_FFFE, hold md_stall 3 cycles → counter 32'hFFFF_FFFF and stays there.
